// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter for four writers (ALU, load unit, link writer, CP0 move).
// One winner is latched per transfer and presented with a valid/ready handshake; a write to
// register 0 is consumed without ever being presented.
// Build option: define WB_ARB_FIXED_PRIO_EN for fixed priority (req0 highest); default is
// round-robin.
module wb_port_arbiter #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [ADDR_W-1:0] addr2,
  input  logic [ADDR_W-1:0] addr3,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  input  logic [DATA_W-1:0] data2,
  input  logic [DATA_W-1:0] data3,
  output logic [3:0]        ack,
  output logic [1:0]        mux_sel,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

`ifdef WB_ARB_FIXED_PRIO_EN
  localparam logic RoundRobin = 1'b0;
`else
  localparam logic RoundRobin = 1'b1;
`endif

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e            state_q;
  logic [1:0]        ptr_q;
  logic [1:0]        mux_sel_q;
  logic              wr_en_q;
  logic              busy_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  logic              accept;
  logic [3:0]        cand;
  logic [1:0]        arb_ptr;
  logic [7:0]        cand_dbl;
  logic [3:0]        rot;
  logic [1:0]        win_off;
  logic              win_found;
  logic [1:0]        win_idx;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              load;
  logic              to_idle;

  // The latched write completes when the file takes it, or at once if it targets register 0.
  always_comb begin
    accept = (state_q == StGrant) && ((wr_en_q && wr_ready) || (wr_addr_q == '0));
    ack    = '0;
    if (accept) begin
      ack[mux_sel_q] = 1'b1;
    end
  end

  // Requests eligible this cycle and the rotation start point. In round-robin mode the requester
  // being acked is masked so its still-high req cannot win again; with fixed priority it stays
  // eligible, so a continuously requesting req0 keeps the port.
  always_comb begin
    cand    = req;
    arb_ptr = ptr_q;
    if (accept && RoundRobin) begin
      cand    = req & ~(4'b0001 << mux_sel_q);
      arb_ptr = mux_sel_q + 2'd1;
    end
  end

  // Rotate so the highest-priority index sits at bit 0, then take the first set bit.
  always_comb begin
    cand_dbl  = {cand, cand};
    rot       = cand_dbl[arb_ptr +: 4];
    win_found = |rot;
    if (rot[0]) begin
      win_off = 2'd0;
    end else if (rot[1]) begin
      win_off = 2'd1;
    end else if (rot[2]) begin
      win_off = 2'd2;
    end else begin
      win_off = 2'd3;
    end
    win_idx = arb_ptr + win_off;
  end

  // 4:1 address/data mux steered by the winning index.
  always_comb begin
    win_addr = addr0;
    win_data = data0;
    unique case (win_idx)
      2'd0: begin
        win_addr = addr0;
        win_data = data0;
      end
      2'd1: begin
        win_addr = addr1;
        win_data = data1;
      end
      2'd2: begin
        win_addr = addr2;
        win_data = data2;
      end
      2'd3: begin
        win_addr = addr3;
        win_data = data3;
      end
    endcase
  end

  // A new write is latched from IDLE or in the cycle the current one is accepted.
  always_comb begin
    load    = win_found && ((state_q == StIdle) || accept);
    to_idle = accept && !win_found;
  end

  // Arbiter FSM with registered outputs; reset drops any write in flight without an ack.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      mux_sel_q <= 2'd0;
      wr_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      if (accept && RoundRobin) begin
        ptr_q <= mux_sel_q + 2'd1;
      end
      if (load) begin
        state_q   <= StGrant;
        mux_sel_q <= win_idx;
        wr_addr_q <= win_addr;
        wr_data_q <= win_data;
        wr_en_q   <= (win_addr != '0);
        busy_q    <= 1'b1;
      end else if (to_idle) begin
        state_q   <= StIdle;
        wr_addr_q <= '0;
        wr_data_q <= '0;
        wr_en_q   <= 1'b0;
        busy_q    <= 1'b0;
      end
    end
  end

  assign mux_sel = mux_sel_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios followed by randomized traffic, checked by a
// cycle reference model plus a queue scoreboard of granted writes popped on every ack.
module tb_wb_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;

`ifdef WB_ARB_FIXED_PRIO_EN
  localparam bit RR = 1'b0;
`else
  localparam bit RR = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    req = 4'b0;
  logic [AW-1:0] addr [4];
  logic [DW-1:0] data [4];
  logic          wr_ready = 1'b0;
  logic [3:0]    ack;
  logic [1:0]    mux_sel;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;

  always #5 clk = ~clk;

  wb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .addr0   (addr[0]),
    .addr1   (addr[1]),
    .addr2   (addr[2]),
    .addr3   (addr[3]),
    .data0   (data[0]),
    .data1   (data[1]),
    .data2   (data[2]),
    .data3   (data[3]),
    .ack     (ack),
    .mux_sel (mux_sel),
    .wr_en   (wr_en),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy)
  );

  typedef struct packed {
    logic [1:0]    idx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sb[$];
  int            ack_log[$];
  int            ack_cyc[$];
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;
  bit            saw_wr_en;
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;
  bit            hold = 1'b0;
  bit            rnd = 1'b0;

  // Reference model: which requester holds the port and the current highest-priority index.
  bit            m_busy = 1'b0;
  int            m_idx = 0;
  int            m_ptr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit            m_acc = 1'b0;
  int            m_acc_idx = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int pick(logic [3:0] r, int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge using the inputs the DUT samples there.
  task automatic model_edge();
    logic [3:0] r;
    int w;
    m_acc = 1'b0;
    r = req;
    if (!rst_n) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      sb.delete();
      return;
    end
    if (m_busy) begin
      if (m_addr == '0 || wr_ready) begin
        m_acc     = 1'b1;
        m_acc_idx = m_idx;
        if (RR) begin
          m_ptr = (m_idx + 1) % 4;
          r[m_idx] = 1'b0;
        end
      end else begin
        return;
      end
    end
    w = pick(r, m_ptr);
    if (w >= 0) begin
      m_busy = 1'b1;
      m_idx  = w;
      m_addr = addr[w];
      m_data = data[w];
      sb.push_back(wr_t'{idx: 2'(w), a: addr[w], d: data[w]});
    end else begin
      m_busy = 1'b0;
    end
  endtask

  task automatic rand_stim();
    for (int i = 0; i < 4; i++) begin
      if (!req[i] && !(m_busy && m_idx == i) && $urandom_range(2) == 0) begin
        addr[i] = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
        data[i] = $urandom;
        req[i]  = 1'b1;
      end else if (req[i] && m_busy && m_idx == i && $urandom_range(15) == 0) begin
        req[i] = 1'b0;
      end
    end
    wr_ready = ($urandom_range(3) != 0);
  endtask

  // One clock: model follows the edge, then requesters react (drop req once acked).
  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    if (m_acc && !hold) req[m_acc_idx] = 1'b0;
    if (rnd) rand_stim();
  endtask

  task automatic wait_acks(int n, int budget);
    int target;
    target = ack_log.size() + n;
    for (int t = 0; t < budget && ack_log.size() < target; t++) step();
    if (ack_log.size() < target) chk("ack_timeout", 64'(ack_log.size()), 64'(target));
  endtask

  task automatic drain();
    wr_ready = 1'b1;
    for (int t = 0; t < 100 && (req != 4'b0 || m_busy); t++) step();
    chk("drain_timeout", {63'b0, (req != 4'b0 || m_busy)}, 64'd0);
  endtask

  task automatic clear_log();
    ack_log.delete();
    ack_cyc.delete();
  endtask

  // Monitor: cycle check against the model, and scoreboard pop whenever the DUT acks.
  logic [3:0] ea;
  wr_t        e;
  always @(negedge clk) begin
    if (mon_en) begin
      ea = (m_busy && (m_addr == '0 || wr_ready)) ? 4'(1 << m_idx) : 4'b0;
      chk("ack", 64'(ack), 64'(ea));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("wr_en", 64'(wr_en), 64'(m_busy && m_addr != '0));
      if (m_busy) begin
        chk("mux_sel", 64'(mux_sel), 64'(m_idx));
        chk("wr_addr", 64'(wr_addr), 64'(m_addr));
        chk("wr_data", 64'(wr_data), 64'(m_data));
      end else begin
        chk("idle_addr", 64'(wr_addr), 64'd0);
        chk("idle_data", 64'(wr_data), 64'd0);
      end
      if (wr_en) saw_wr_en = 1'b1;
      if (ack != 4'b0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", 64'(ack), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_ack", 64'(ack), 64'(4'b0001 << e.idx));
          chk("sb_sel", 64'(mux_sel), 64'(e.idx));
          if (e.a != '0) begin
            chk("sb_addr", 64'(wr_addr), 64'(e.a));
            chk("sb_data", 64'(wr_data), 64'(e.d));
          end
        end
        for (int i = 0; i < 4; i++) begin
          if (ack[i]) ack_log.push_back(i);
        end
        ack_cyc.push_back(cyc);
        last_addr = wr_addr;
        last_data = wr_data;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp3[5];
    int exp6[3];
    int c0;
    for (int i = 0; i < 4; i++) begin
      addr[i] = '0;
      data[i] = '0;
    end
    if (RR) begin
      exp3 = '{0, 1, 2, 3, 0};
      exp6 = '{2, 3, 0};
    end else begin
      exp3 = '{0, 0, 0, 0, 0};
      exp6 = '{2, 0, 0};
    end

    rst_n = 1'b0;
    step();
    step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_mux_sel", 64'(mux_sel), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);

    // Reset mid-transfer: first move the pointer off 0, then stall a write and reset.
    wr_ready = 1'b1;
    addr[1]  = 5'd3;
    data[1]  = 32'h1;
    req      = 4'b0010;
    wait_acks(1, 10);
    wr_ready = 1'b0;
    addr[2]  = 5'd9;
    data[2]  = 32'h1234;
    req      = 4'b0100;
    step();
    step();
    chk("t1_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t1_wr_en", 64'(wr_en), 64'd0);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_ack", 64'(ack), 64'd0);
    req = 4'b0;
    step();

    // Fairness with all four held; first grant 0 also shows the pointer was reset.
    clear_log();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr[i] = AW'(i + 1);
      data[i] = 32'hA0 + i;
    end
    wr_ready = 1'b1;
    req      = 4'b1111;
    wait_acks(5, 20);
    for (int k = 0; k < 5; k++) begin
      if (k < ack_log.size()) chk("t3_order", 64'(ack_log[k]), 64'(exp3[k]));
    end
    for (int k = 1; k < 5; k++) begin
      if (k < ack_cyc.size()) chk("t3_b2b", 64'(ack_cyc[k] - ack_cyc[k-1]), 64'd1);
    end
    hold = 1'b0;
    req  = 4'b0;
    drain();

    // Single write, one cycle from req to the presented write.
    clear_log();
    addr[0]  = 5'd8;
    data[0]  = 32'hDEAD_BEEF;
    wr_ready = 1'b1;
    req      = 4'b0001;
    c0       = cyc;
    wait_acks(1, 10);
    if (ack_log.size() > 0) begin
      chk("t2_idx", 64'(ack_log[0]), 64'd0);
      chk("t2_lat", 64'(ack_cyc[0] - c0), 64'd1);
      chk("t2_addr", 64'(last_addr), 64'd8);
      chk("t2_data", 64'(last_data), 64'hDEAD_BEEF);
    end

    // Backpressure: held stable for three stalled cycles, ack once ready rises.
    clear_log();
    addr[2]  = 5'd17;
    data[2]  = 32'hCAFE_F00D;
    wr_ready = 1'b0;
    req      = 4'b0100;
    step();
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_wr_en", 64'(wr_en), 64'd1);
      chk("t4_mux_sel", 64'(mux_sel), 64'd2);
      chk("t4_ack", 64'(ack), 64'd0);
      chk("t4_wr_addr", 64'(wr_addr), 64'd17);
      chk("t4_wr_data", 64'(wr_data), 64'hCAFE_F00D);
    end
    chk("t4_no_ack", 64'(ack_log.size()), 64'd0);
    wr_ready = 1'b1;
    #1;
    chk("t4_ack_ready", 64'(ack), 64'b0100);
    wait_acks(1, 5);

    // Write to register 0 is consumed without wr_en, even with wr_ready low.
    clear_log();
    saw_wr_en = 1'b0;
    addr[1]   = 5'd0;
    data[1]   = 32'hFFFF;
    wr_ready  = 1'b0;
    req       = 4'b0010;
    c0        = cyc;
    wait_acks(1, 10);
    if (ack_log.size() > 0) begin
      chk("t5_idx", 64'(ack_log[0]), 64'd1);
      chk("t5_lat", 64'(ack_cyc[0] - c0), 64'd1);
    end
    chk("t5_no_wr_en", 64'(saw_wr_en), 64'd0);

    // Pointer wrap: after an ack on 2, requester 3 outranks requester 0.
    clear_log();
    wr_ready = 1'b1;
    addr[2]  = 5'd4;
    req      = 4'b0100;
    wait_acks(1, 10);
    addr[0] = 5'd6;
    addr[3] = 5'd7;
    req     = 4'b1001;
    wait_acks(2, 10);
    for (int k = 0; k < 3; k++) begin
      if (k < ack_log.size()) chk("t6_order", 64'(ack_log[k]), 64'(exp6[k]));
    end
    drain();

    // Randomized traffic with occasional resets.
    rnd = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(299) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    rnd = 1'b0;
    drain();
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
